// File: rtl/time_pkg.sv
// time_pkg: shared constants and state encoding for the BCD time composer
package time_pkg;
    localparam int SEC_PER_MIN  = 60;
    localparam int DIGIT_MAX    = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int ACC_W = $clog2((DIGIT_MAX * 10 + DIGIT_MAX) * SEC_PER_MIN
                                  + SEC_TENS_MAX * 10 + DIGIT_MAX + 1);
    typedef enum logic [1:0] {IDLE, S_MIN, S_SEC, S_OUT} state_t;
endpackage

// File: rtl/time_mul10.sv
// time_mul10: constant multiply by ten built from two shifts and an add
module time_mul10 #(
    parameter int W = 13
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = (x << 3) + (x << 1);
endmodule

// File: rtl/time_composer.sv
// time_composer: converts latched BCD MM:SS digits into a seconds count; define TIME_COMPOSER_SAT_EN to saturate on overflow
module time_composer
    import time_pkg::*;
#(
    parameter int TIMER_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [6:0]         min_decimal,
    input  logic [6:0]         min_unit,
    input  logic [6:0]         sec_decimal,
    input  logic [6:0]         sec_unit,
    output logic [TIMER_W-1:0] timer,
    output logic               busy,
    output logic               valid,
    output logic               err,
    output logic               ovf
);
    localparam logic [31:0] TMAX = (32'd1 << TIMER_W) - 32'd1;
    state_t           state;
    logic [6:0]       md, mu, sd, su;
    logic [ACC_W-1:0] acc, mul_in, m_a, m_b;
    logic [TIMER_W-1:0] ovf_val;
    logic             bad, big;
    assign mul_in = (state == S_MIN) ? ACC_W'(md) : acc;
    time_mul10 #(.W(ACC_W)) u_mul_a (.x(mul_in), .y(m_a));
    time_mul10 #(.W(ACC_W)) u_mul_b (.x(ACC_W'(sd)), .y(m_b));
    assign bad = (md > 7'(DIGIT_MAX)) || (mu > 7'(DIGIT_MAX)) ||
                 (sd > 7'(SEC_TENS_MAX)) || (su > 7'(DIGIT_MAX));
    assign big = {{(32-ACC_W){1'b0}}, acc} > TMAX;
`ifdef TIME_COMPOSER_SAT_EN
    assign ovf_val = '1;
`else
    assign ovf_val = TIMER_W'(acc);
`endif
    // conversion sequencer: latch digits, minutes, minutes*60 + seconds, publish result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            md    <= '0;
            mu    <= '0;
            sd    <= '0;
            su    <= '0;
            timer <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            err   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    md    <= min_decimal;
                    mu    <= min_unit;
                    sd    <= sec_decimal;
                    su    <= sec_unit;
                    busy  <= 1'b1;
                    state <= S_MIN;
                end
                S_MIN: begin
                    acc   <= m_a + ACC_W'(mu);
                    state <= S_SEC;
                end
                S_SEC: begin
                    acc   <= (m_a << 2) + (m_a << 1) + m_b + ACC_W'(su);
                    state <= S_OUT;
                end
                default: begin
                    timer <= bad ? '0 : big ? ovf_val : TIMER_W'(acc);
                    err   <= bad;
                    ovf   <= !bad && big;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_time_composer.sv
// tb_time_composer: randomized scoreboard bench for time_composer
module tb_time_composer;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [6:0]  md = '0, mu = '0, sd = '0, su = '0;
    logic [10:0] timer;
    logic        busy, valid, err, ovf;
    int          vec = 0, bad = 0, cyc = 0;
    typedef struct {int t; logic e; logic o; int due;} exp_t;
    exp_t q[$];

    time_composer #(.TIMER_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .min_decimal(md), .min_unit(mu), .sec_decimal(sd), .sec_unit(su),
        .timer(timer), .busy(busy), .valid(valid), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(int a, int b, int c, int d, int due);
        exp_t r;
        int tot;
        tot   = (a * 10 + b) * 60 + c * 10 + d;
        r.e   = (a > 9) || (b > 9) || (c > 5) || (d > 9);
        r.o   = !r.e && tot > 2047;
`ifdef TIME_COMPOSER_SAT_EN
        r.t   = r.e ? 0 : r.o ? 2047 : tot;
`else
        r.t   = r.e ? 0 : r.o ? tot % 2048 : tot;
`endif
        r.due = due;
        return r;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        vec++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got %0d want %0d (t=%0t)", n, a, e, $time);
        end
    endtask

    // scoreboard monitor: every valid pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (q.size() == 0) chk("spurious_valid", {31'b0, valid}, 0);
            else begin
                exp_t x;
                x = q.pop_front();
                chk("latency", cyc, x.due);
                chk("timer", {21'b0, timer}, x.t);
                chk("err", {31'b0, err}, {31'b0, x.e});
                chk("ovf", {31'b0, ovf}, {31'b0, x.o});
            end
        end
    end

    task automatic issue(int a, int b, int c, int d);
        md = 7'(a); mu = 7'(b); sd = 7'(c); su = 7'(d);
        start = 1'b1;
        q.push_back(model(a, b, c, d, cyc + 4));
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("timeout_pending", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic chk_zero(string n);
        chk({n, "_timer"}, {21'b0, timer}, 0);
        chk({n, "_busy"}, {31'b0, busy}, 0);
        chk({n, "_valid"}, {31'b0, valid}, 0);
        chk({n, "_err"}, {31'b0, err}, 0);
        chk({n, "_ovf"}, {31'b0, ovf}, 0);
    endtask

    initial begin
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 5, 3, 0);
        for (int i = 0; i < 3; i++) begin
            chk("busy_high", {31'b0, busy}, 1);
            @(posedge clk); #1;
        end
        chk("busy_low_after", {31'b0, busy}, 0);
        wait_done();
        issue(3, 4, 0, 7); wait_done();
        issue(3, 4, 0, 8); wait_done();
        issue(9, 9, 5, 9); wait_done();
        issue(1, 2, 6, 0); wait_done();
        issue(0, 10, 0, 0); wait_done();
        md = 7'd1; mu = 7'd0; sd = 7'd0; su = 7'd0;
        start = 1'b1;
        q.push_back(model(1, 0, 0, 0, cyc + 4));
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        issue(2, 3, 4, 5);
        repeat (3) @(posedge clk);
        #1 issue(0, 0, 1, 9);
        wait_done();
        repeat (2) @(negedge clk);
        issue(5, 5, 5, 5);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(0, 0, 0, 1); wait_done();
        for (int k = 0; k < 40; k++) begin
            issue($urandom_range(0, 11), $urandom_range(0, 11),
                  $urandom_range(0, 7), $urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) begin
                repeat (3) @(posedge clk);
                #1 issue($urandom_range(0, 9), $urandom_range(0, 9),
                         $urandom_range(0, 5), $urandom_range(0, 9));
            end
            wait_done();
        end
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule
